// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg: shared types and constants for the shift issue path.
//   shift_type_t   - shifter operation select (consumed by the shifter)
//   OP_* / F3_* / F7_* - instruction field encodings of the shift instructions
//   shift_entry_t  - one buffered shifter request {a, shamt, sh_type, rd, illegal}
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int unsigned SH_XLEN  = 32;
  localparam int unsigned SH_TAG_W = 5;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10
  } shift_type_t;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef struct packed {
    logic [SH_XLEN-1:0]  a;
    logic [SHAMT_W-1:0]  shamt;
    shift_type_t         sh_type;
    logic [SH_TAG_W-1:0] rd;
    logic                illegal;
  } shift_entry_t;

endpackage

// File: rtl/shift_decode.sv
// -----------------------------------------------------------------------------
// shift_decode: combinational map of opcode/funct fields to shifter controls.
// Ports:
//   opcode_i, funct3_i, funct7_i - instruction fields (funct7 = imm[11:5] for I-type)
//   reg_shamt_i  - shamt candidate from the register operand (R-type)
//   imm_shamt_i  - shamt candidate from the immediate (I-type)
//   shamt_c_o, type_c_o, illegal_c_o - decoded controls (combinational)
// -----------------------------------------------------------------------------
module shift_decode
  import shift_pkg::*;
(
  input  logic [6:0]         opcode_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic [SHAMT_W-1:0] reg_shamt_i,
  input  logic [SHAMT_W-1:0] imm_shamt_i,
  output logic [SHAMT_W-1:0] shamt_c_o,
  output shift_type_t        type_c_o,
  output logic               illegal_c_o
);

  // Illegal unless a known opcode/funct3/funct7 triple matches; illegal entries
  // issue as SLL by 0 so the shifter never sees an undefined type.
  always_comb begin
    shamt_c_o   = '0;
    type_c_o    = SLL;
    illegal_c_o = 1'b1;
    if ((opcode_i == OP_REG) || (opcode_i == OP_IMM)) begin
      case (funct3_i)
        F3_SLL: begin
          if (funct7_i == F7_ZERO) begin
            type_c_o    = SLL;
            illegal_c_o = 1'b0;
          end
        end
        F3_SR: begin
          if (funct7_i == F7_ZERO) begin
            type_c_o    = SRL;
            illegal_c_o = 1'b0;
          end else if (funct7_i == F7_SRA) begin
            type_c_o    = SRA;
            illegal_c_o = 1'b0;
          end
        end
        default: ;
      endcase
      if (!illegal_c_o) begin
        shamt_c_o = (opcode_i == OP_REG) ? reg_shamt_i : imm_shamt_i;
      end
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage: decodes shift instructions and issues registered shifter
// controls through a 2-entry skid buffer (main entry drives out_*).
// Ports:
//   clk, rst_n (async active-low), flush (sync, drops all buffered entries)
//   in_valid/in_ready  - decode-side handshake; in_ready is registered
//   in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val, in_imm, in_rd
//   out_valid/out_ready - shifter-side handshake
//   out_a, out_shamt, out_type, out_rd, out_illegal - registered shifter inputs
// Optional: `define SHIFT_ISSUE_FWD_EN adds fwd_valid, fwd_rd, fwd_val, in_rs1,
//   in_rs2 and forwards fwd_val into operand a / R-type shamt at capture.
// -----------------------------------------------------------------------------
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN  = SH_XLEN,
  parameter int unsigned TAG_W = SH_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  input  logic [11:0]      in_imm,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [4:0]       out_shamt,
  output logic [1:0]       out_type,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_illegal
`ifdef SHIFT_ISSUE_FWD_EN
  ,
  input  logic             fwd_valid,
  input  logic [TAG_W-1:0] fwd_rd,
  input  logic [XLEN-1:0]  fwd_val,
  input  logic [TAG_W-1:0] in_rs1,
  input  logic [TAG_W-1:0] in_rs2
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

  buf_state_t   state_q, state_d;
  shift_entry_t main_q, main_d;
  shift_entry_t skid_q, skid_d;
  shift_entry_t new_entry;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         in_fire;
  logic         out_fire;

  logic [XLEN-1:0]    rs1_sel;
  logic [SHAMT_W-1:0] rs2_shamt;
  logic [SHAMT_W-1:0] dec_shamt;
  shift_type_t        dec_type;
  logic               dec_illegal;

  // Only the low shamt bits of rs2 and imm feed the shifter.
  logic unused_bits;
  assign unused_bits = ^{in_rs2_val[XLEN-1:SHAMT_W], in_imm[11:SHAMT_W]};

  // Operand selection; forwarding only affects the entry being captured.
`ifdef SHIFT_ISSUE_FWD_EN
  logic fwd_rs1_hit;
  logic fwd_rs2_hit;
  assign fwd_rs1_hit = fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs1);
  assign fwd_rs2_hit = fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs2);
  assign rs1_sel     = fwd_rs1_hit ? fwd_val : in_rs1_val;
  assign rs2_shamt   = fwd_rs2_hit ? fwd_val[SHAMT_W-1:0] : in_rs2_val[SHAMT_W-1:0];
`else
  assign rs1_sel     = in_rs1_val;
  assign rs2_shamt   = in_rs2_val[SHAMT_W-1:0];
`endif

  shift_decode u_decode (
    .opcode_i    (in_opcode),
    .funct3_i    (in_funct3),
    .funct7_i    (in_funct7),
    .reg_shamt_i (rs2_shamt),
    .imm_shamt_i (in_imm[SHAMT_W-1:0]),
    .shamt_c_o   (dec_shamt),
    .type_c_o    (dec_type),
    .illegal_c_o (dec_illegal)
  );

  always_comb begin
    new_entry.a       = rs1_sel;
    new_entry.shamt   = dec_shamt;
    new_entry.sh_type = dec_type;
    new_entry.rd      = in_rd;
    new_entry.illegal = dec_illegal;
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Buffer next-state; FULL never sees in_fire because in_ready is low there.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            skid_d  = new_entry;
            state_d = FULL;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   main_d  = new_entry;
          default: ;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a same-cycle input.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Handshake flags are registered from the next state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_a       = main_q.a;
  assign out_shamt   = main_q.shamt;
  assign out_type    = main_q.sh_type;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage: directed stimulus with a queue-based reference model of
// the issue stage; every negedge compares the DUT against the model, and the
// directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic [11:0] in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_type;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef SHIFT_ISSUE_FWD_EN
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_val = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
`endif

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_shamt   (out_shamt),
    .out_type    (out_type),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
`ifdef SHIFT_ISSUE_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_val     (fwd_val),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Shift instruction semantics: which encodings are legal and what they issue.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [4:0] rsh, input logic [11:0] imm,
                                 input logic [4:0] rd);
    exp_t e;
    e.a = a; e.rd = rd; e.ill = 1'b1; e.ty = 2'b00; e.shamt = 5'd0;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      if (f3 == 3'b001 && f7 == 7'b0000000)      begin e.ill = 1'b0; e.ty = 2'b00; end
      else if (f3 == 3'b101 && f7 == 7'b0000000) begin e.ill = 1'b0; e.ty = 2'b01; end
      else if (f3 == 3'b101 && f7 == 7'b0100000) begin e.ill = 1'b0; e.ty = 2'b10; end
      if (!e.ill) e.shamt = (op == 7'b0110011) ? rsh : imm[4:0];
    end
    return e;
  endfunction

  // Reference: a FIFO of at most 2 entries; ready while fewer than 2 are held.
  logic        m_ifire, m_ofire;
  logic [31:0] m_a;
  logic [4:0]  m_rsh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_ifire = in_valid && (mq.size() < 2);
      m_ofire = out_ready && (mq.size() > 0);
      m_a     = in_rs1_val;
      m_rsh   = in_rs2_val[4:0];
`ifdef SHIFT_ISSUE_FWD_EN
      if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs1) m_a = fwd_val;
      if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs2) m_rsh = fwd_val[4:0];
`endif
      if (m_ofire) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (m_ifire) mq.push_back(model(in_opcode, in_funct3, in_funct7, m_a, m_rsh, in_imm, in_rd));
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_fields", {out_a[26:0], out_shamt} ^ {27'd0, 5'd0}, 32'd0);
      chk("rst_out_misc", {25'd0, out_type, out_rd, out_illegal}, 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
        chk("out_a", out_a, mq[0].a);
        chk("out_shamt", 32'(out_shamt), 32'(mq[0].shamt));
        chk("out_type", 32'(out_type), 32'(mq[0].ty));
        chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
        chk("out_illegal", 32'(out_illegal), 32'(mq[0].ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [11:0] imm, input logic [4:0] rd);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_rd = rd;
    in_valid = 1'b1;
  endtask

  // Present and hold until accepted (bounded), then drop in_valid.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [11:0] imm, input logic [4:0] rd);
    int n;
    present(op, f3, f7, rs1, rs2, imm, rd);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  exp_t pin;

  initial begin
    // Pin the reference model against hand-derived decodes.
    pin = model(R, 3'b101, 7'b0100000, 32'h80000010, 5'd4, 12'h000, 5'd1);
    chk("pin_sra_type", 32'(pin.ty), 32'd2);
    chk("pin_sra_shamt", 32'(pin.shamt), 32'd4);
    pin = model(I, 3'b001, 7'b0100000, 32'h1, 5'd0, 12'h405, 5'd1);
    chk("pin_bad_slli_ill", 32'(pin.ill), 32'd1);
    chk("pin_bad_slli_shamt", 32'(pin.shamt), 32'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // 1: R-type SRA, latency 1; rs2 upper bits ignored.
    send(R, 3'b101, 7'b0100000, 32'h80000010, 32'h00000024, 12'h000, 5'd1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_a", out_a, 32'h80000010);
    chk("t1_shamt", 32'(out_shamt), 32'd4);
    chk("t1_type", 32'(out_type), 32'd2);
    chk("t1_ill", 32'(out_illegal), 32'd0);
    out_ready = 1'b1;
    tick();

    // 2: I-type SLLI, illegal SLLI, SRLI, bad opcode, streaming with out_ready=1.
    send(I, 3'b001, 7'b0000000, 32'h00001234, 32'hFFFFFFFF, 12'h005, 5'd2);
    chk("t2_slli_shamt", 32'(out_shamt), 32'd5);
    chk("t2_slli_type", 32'(out_type), 32'd0);
    chk("t2_slli_ill", 32'(out_illegal), 32'd0);
    send(I, 3'b001, 7'b0100000, 32'h0000CAFE, 32'h0, 12'h405, 5'd3);
    chk("t2_bad_ill", 32'(out_illegal), 32'd1);
    chk("t2_bad_type", 32'(out_type), 32'd0);
    chk("t2_bad_shamt", 32'(out_shamt), 32'd0);
    chk("t2_bad_a", out_a, 32'h0000CAFE);
    send(I, 3'b101, 7'b0000000, 32'h0000BEEF, 32'h0, 12'h01F, 5'd4);
    chk("t2_srli_type", 32'(out_type), 32'd1);
    send(7'b0110111, 3'b001, 7'b0000000, 32'h00000077, 32'h3, 12'h003, 5'd5);
    chk("t2_badop_ill", 32'(out_illegal), 32'd1);
    tick();
    out_ready = 1'b0;

    // 3: back-pressure with 3 back-to-back instructions.
    send(R, 3'b001, 7'b0000000, 32'h00000101, 32'h1, 12'h0, 5'd6);
    send(R, 3'b101, 7'b0000000, 32'h00000202, 32'h2, 12'h0, 5'd7);
    present(R, 3'b101, 7'b0100000, 32'h00000303, 32'h3, 12'h0, 5'd8);
    tick();
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_head_first", out_a, 32'h00000101);
    out_ready = 1'b1;
    send(R, 3'b101, 7'b0100000, 32'h00000303, 32'h3, 12'h0, 5'd8);
    chk("t3_last_out", out_a, 32'h00000303);
    repeat (2) tick();
    out_ready = 1'b0;

    // 4: ONE with input and output every cycle.
    send(I, 3'b001, 7'b0000000, 32'h00000400, 32'h0, 12'h001, 5'd9);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(I, 3'b001, 7'b0000000, 32'h00000410 + 32'(i), 32'h0, 12'h002 + 12'(i), 5'(10 + i));
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // 5: flush from FULL and from ONE with a concurrent input.
    send(R, 3'b001, 7'b0000000, 32'h00000501, 32'h1, 12'h0, 5'd14);
    send(R, 3'b001, 7'b0000000, 32'h00000502, 32'h2, 12'h0, 5'd15);
    present(R, 3'b001, 7'b0000000, 32'h00000503, 32'h3, 12'h0, 5'd16);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_full_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_full_flush_ready", 32'(in_ready), 32'd1);
    send(R, 3'b001, 7'b0000000, 32'h00000511, 32'h1, 12'h0, 5'd17);
    present(R, 3'b001, 7'b0000000, 32'h00000512, 32'h2, 12'h0, 5'd18);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_one_flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t5_no_emit", 32'(out_valid), 32'd0);

    // 6: asynchronous reset while FULL.
    send(R, 3'b001, 7'b0000000, 32'h00000601, 32'h1, 12'h0, 5'd19);
    send(R, 3'b001, 7'b0000000, 32'h00000602, 32'h2, 12'h0, 5'd20);
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("t6_after_reset", 32'(out_valid), 32'd0);

`ifdef SHIFT_ISSUE_FWD_EN
    // Forwarding hit on rs1, then fwd_rd=0 which must not forward.
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_val = 32'hDEADBEEF; in_rs1 = 5'd3; in_rs2 = 5'd7;
    send(R, 3'b001, 7'b0000000, 32'h00000011, 32'h2, 12'h0, 5'd21);
    chk("fwd_hit_a", out_a, 32'hDEADBEEF);
    chk("fwd_hit_shamt", 32'(out_shamt), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    fwd_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    send(R, 3'b001, 7'b0000000, 32'h00000011, 32'h2, 12'h0, 5'd22);
    chk("fwd_zero_a", out_a, 32'h00000011);
    fwd_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
